// File: rtl/cpu_mc_if.sv
// cpu_mc_if: instruction-fetch and data-memory bus of the cpu_mc core.
//   master (core) drives : inst_addr, read, write, address, dout
//   master (core) samples: inst, din, mem_ready
//   slave (memory side) is the mirror image.
interface cpu_mc_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 8
);
   logic [AW-1:0] inst_addr;
   logic [15:0]   inst;
   logic          read;
   logic          write;
   logic [AW-1:0] address;
   logic [DW-1:0] dout;
   logic [DW-1:0] din;
   logic          mem_ready;

   modport master (
      output inst_addr, read, write, address, dout,
      input  inst, din, mem_ready
   );

   modport slave (
      input  inst_addr, read, write, address, dout,
      output inst, din, mem_ready
   );
endinterface

// File: rtl/cpu_mc.sv
// cpu_mc: small multi-cycle CPU. One instruction per cycle in EXEC; LOAD/STORE
// park in MEM until mem_ready; HALT is left only by rst. R0 is the PC.
//   clk, rst  : clock, synchronous active-high reset
//   run       : execute enable (ignored while an access is in flight)
//   halted    : registered, set once HALT has executed
//   bus       : cpu_mc_if master (fetch address/data, data read/write bus)
module cpu_mc #(
   parameter int unsigned DW   = 8,
   parameter int unsigned AW   = 8,
   parameter int unsigned NREG = 16
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     run,
   output logic     halted,
   cpu_mc_if.master bus
);
   localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [1:0] {
      EXEC = 2'd0,
      MEM  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] regs [NREG];
   logic [DW-1:0] pc;
   logic [DW-1:0] pc_nxt;

   logic [3:0]    op;
   logic [3:0]    dest;
   logic [3:0]    arg1;
   logic [3:0]    arg2;
   logic [DW-1:0] cnst;
   logic [DW-1:0] r_dest;
   logic [DW-1:0] r_arg1;
   logic [DW-1:0] r_arg2;
   logic [DW-1:0] alu;

   logic          wr_en;
   logic [3:0]    wr_idx;
   logic [DW-1:0] wr_data;

   logic [3:0]    mem_dest;
   logic [3:0]    mem_dest_nxt;
   logic          read_nxt;
   logic          write_nxt;
   logic [AW-1:0] address_nxt;
   logic [DW-1:0] dout_nxt;
   logic          halted_nxt;

   assign pc            = regs[0];
   assign bus.inst_addr = pc[AW-1:0];

   // Instruction fields
   assign op   = bus.inst[15:12];
   assign dest = bus.inst[11:8];
   assign arg1 = bus.inst[7:4];
   assign arg2 = bus.inst[3:0];
   assign cnst = DW'(bus.inst[7:0]);

   // Register reads; indices beyond the file alias R0
   assign r_dest = (32'(dest) < NREG) ? regs[dest[IW-1:0]] : pc;
   assign r_arg1 = (32'(arg1) < NREG) ? regs[arg1[IW-1:0]] : pc;
   assign r_arg2 = (32'(arg2) < NREG) ? regs[arg2[IW-1:0]] : pc;

   // ALU; shift amounts of DW or more flush to zero
   always_comb begin
      alu = '0;
      case (op)
         4'h4:    alu = DW'(r_arg1 < r_arg2);
         4'h5:    alu = DW'(r_arg1 == r_arg2);
         4'h8:    alu = r_arg1 + r_arg2;
         4'h9:    alu = r_arg1 - r_arg2;
         4'hA:    alu = (32'(r_arg2) >= DW) ? '0 : (r_arg1 << r_arg2);
         4'hB:    alu = (32'(r_arg2) >= DW) ? '0 : (r_arg1 >> r_arg2);
         4'hC:    alu = r_arg1 & r_arg2;
         4'hD:    alu = r_arg1 | r_arg2;
         4'hE:    alu = ~r_arg1;
         4'hF:    alu = r_arg1 ^ r_arg2;
         default: alu = '0;
      endcase
   end

   // Next-state, register write and bus outputs
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      wr_en        = 1'b0;
      wr_idx       = dest;
      wr_data      = alu;
      mem_dest_nxt = mem_dest;
      read_nxt     = bus.read;
      write_nxt    = bus.write;
      address_nxt  = bus.address;
      dout_nxt     = bus.dout;
      halted_nxt   = halted;

      case (state)
         EXEC: begin
            if (run) begin
               pc_nxt = pc + DW'(1);
               case (op)
                  4'h0: begin
                     if (dest != 4'd0) begin
                        pc_nxt     = pc;
                        state_nxt  = HALT;
                        halted_nxt = 1'b1;
                     end
                  end
                  4'h1, 4'h2: begin
                     pc_nxt       = pc;
                     address_nxt  = AW'(r_arg1 + DW'(arg2));
                     mem_dest_nxt = dest;
                     state_nxt    = MEM;
                     if (op == 4'h1) begin
                        read_nxt = 1'b1;
                     end else begin
                        write_nxt = 1'b1;
                        dout_nxt  = r_dest;
                     end
                  end
                  4'h3: begin
                     wr_en   = 1'b1;
                     wr_data = cnst;
                  end
                  4'h6: begin
                     if (r_dest == cnst) pc_nxt = pc + DW'(2);
                  end
                  4'h7: begin
                     if (r_dest != cnst) pc_nxt = pc + DW'(2);
                  end
                  default: begin
                     wr_en   = 1'b1;
                     wr_data = alu;
                  end
               endcase
            end
         end
         MEM: begin
            if (bus.mem_ready) begin
               pc_nxt    = pc + DW'(1);
               read_nxt  = 1'b0;
               write_nxt = 1'b0;
               state_nxt = EXEC;
               if (bus.read) begin
                  wr_en   = 1'b1;
                  wr_idx  = mem_dest;
                  wr_data = bus.din;
               end
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = EXEC;
         end
      endcase

      // A write to R0 replaces the PC update (register jump)
      if (wr_en && wr_idx == 4'd0) pc_nxt = wr_data;
   end

   // State and register file
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
         state       <= EXEC;
         mem_dest    <= '0;
         bus.read    <= 1'b0;
         bus.write   <= 1'b0;
         bus.address <= '0;
         bus.dout    <= '0;
         halted      <= 1'b0;
      end else begin
         state   <= state_nxt;
         regs[0] <= pc_nxt;
         for (int i = 1; i < int'(NREG); i++) begin
            if (wr_en && 32'(wr_idx) == 32'(i)) regs[i] <= wr_data;
         end
         mem_dest    <= mem_dest_nxt;
         bus.read    <= read_nxt;
         bus.write   <= write_nxt;
         bus.address <= address_nxt;
         bus.dout    <= dout_nxt;
         halted      <= halted_nxt;
      end
   end
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: two cpu_mc instances (DW=8/NREG=16 and DW=16/NREG=8) run side
// by side against an instruction-level reference model; directed programs
// cover the worked examples, then random programs and random run/ready/rst.
module tb_cpu_mc;
   localparam int unsigned NCYC = 4000;

   logic clk = 1'b0;
   logic rst;
   logic run;
   logic mem_ready;
   logic halted0;
   logic halted1;

   cpu_mc_if #(.DW(8),  .AW(8)) bus0 ();
   cpu_mc_if #(.DW(16), .AW(8)) bus1 ();

   logic [15:0] imem0 [256];
   logic [15:0] imem1 [256];
   logic [7:0]  dmem0 [256];
   logic [15:0] dmem1 [256];

   cpu_mc #(.DW(8), .AW(8), .NREG(16)) dut0 (
      .clk(clk), .rst(rst), .run(run), .halted(halted0), .bus(bus0)
   );
   cpu_mc #(.DW(16), .AW(8), .NREG(8)) dut1 (
      .clk(clk), .rst(rst), .run(run), .halted(halted1), .bus(bus1)
   );

   assign bus0.inst      = imem0[bus0.inst_addr];
   assign bus0.din       = dmem0[bus0.address];
   assign bus0.mem_ready = mem_ready;
   assign bus1.inst      = imem1[bus1.inst_addr];
   assign bus1.din       = dmem1[bus1.address];
   assign bus1.mem_ready = mem_ready;

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference model state, per unit. m_st: 0 executing, 1 access pending, 2 halted
   int unsigned m_reg   [2][16];
   int unsigned m_st    [2];
   bit          m_rd    [2];
   bit          m_wr    [2];
   bit          m_hlt   [2];
   int unsigned m_addr  [2];
   int unsigned m_dout  [2];
   int unsigned m_mdest [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned width(input int u);
      return (u == 0) ? 8 : 16;
   endfunction

   function automatic int unsigned nreg(input int u);
      return (u == 0) ? 16 : 8;
   endfunction

   function automatic int unsigned rget(input int u, input int unsigned idx);
      return m_reg[u][(idx < nreg(u)) ? idx : 0];
   endfunction

   function automatic int unsigned dm_rd(input int u, input int unsigned a);
      return (u == 0) ? 32'(dmem0[8'(a)]) : 32'(dmem1[8'(a)]);
   endfunction

   task automatic dm_wr(input int u, input int unsigned a, input int unsigned v);
      if (u == 0) dmem0[8'(a)] = 8'(v);
      else        dmem1[8'(a)] = 16'(v);
   endtask

   // Effect of the coming clock edge on unit u, given the current inputs
   task automatic model_step(input int u);
      int unsigned mask, pc, ins, op, d, a1, a2, k, rdv, ra1, ra2, npc, val, w;
      bit          wr;
      w    = width(u);
      mask = (32'd1 << w) - 1;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_reg[u][i] = 0;
         m_st[u]   = 0;
         m_rd[u]   = 0;
         m_wr[u]   = 0;
         m_addr[u] = 0;
         m_dout[u] = 0;
         m_hlt[u]  = 0;
         return;
      end
      pc = m_reg[u][0];
      if (m_st[u] == 1) begin
         if (mem_ready) begin
            npc = (pc + 1) & mask;
            if (m_rd[u]) begin
               val = dm_rd(u, m_addr[u]);
               if (m_mdest[u] == 0) npc = val;
               else if (m_mdest[u] < nreg(u)) m_reg[u][m_mdest[u]] = val;
            end else begin
               dm_wr(u, m_addr[u], m_dout[u]);
            end
            m_reg[u][0] = npc;
            m_rd[u] = 0;
            m_wr[u] = 0;
            m_st[u] = 0;
         end
         return;
      end
      if (m_st[u] == 2 || !run) return;
      ins = (u == 0) ? 32'(imem0[8'(pc)]) : 32'(imem1[8'(pc)]);
      op  = (ins >> 12) & 15;
      d   = (ins >> 8) & 15;
      a1  = (ins >> 4) & 15;
      a2  = ins & 15;
      k   = ins & 255;
      rdv = rget(u, d);
      ra1 = rget(u, a1);
      ra2 = rget(u, a2);
      npc = (pc + 1) & mask;
      wr  = 1;
      val = 0;
      case (op)
         0: begin
            wr = 0;
            if (d != 0) begin
               npc = pc;
               m_st[u] = 2;
               m_hlt[u] = 1;
            end
         end
         1, 2: begin
            wr = 0;
            npc = pc;
            m_addr[u]  = (ra1 + a2) & 255;
            m_mdest[u] = d;
            m_st[u]    = 1;
            if (op == 1) m_rd[u] = 1;
            else begin
               m_wr[u]   = 1;
               m_dout[u] = rdv;
            end
         end
         3:  val = k;
         4:  val = (ra1 < ra2) ? 1 : 0;
         5:  val = (ra1 == ra2) ? 1 : 0;
         6: begin
            wr = 0;
            if (rdv == k) npc = (pc + 2) & mask;
         end
         7: begin
            wr = 0;
            if (rdv != k) npc = (pc + 2) & mask;
         end
         8:  val = ra1 + ra2;
         9:  val = ra1 - ra2;
         10: val = (ra2 >= w) ? 0 : (ra1 << ra2);
         11: val = (ra2 >= w) ? 0 : (ra1 >> ra2);
         12: val = ra1 & ra2;
         13: val = ra1 | ra2;
         14: val = ~ra1;
         default: val = ra1 ^ ra2;
      endcase
      val = val & mask;
      if (wr) begin
         if (d == 0) npc = val;
         else if (d < nreg(u)) m_reg[u][d] = val;
      end
      m_reg[u][0] = npc;
   endtask

   task automatic compare_all();
      chk("u0.inst_addr", 32'(bus0.inst_addr), m_reg[0][0] & 255);
      chk("u0.read",      32'(bus0.read),      32'(m_rd[0]));
      chk("u0.write",     32'(bus0.write),     32'(m_wr[0]));
      chk("u0.address",   32'(bus0.address),   m_addr[0]);
      chk("u0.dout",      32'(bus0.dout),      m_dout[0]);
      chk("u0.halted",    32'(halted0),        32'(m_hlt[0]));
      chk("u1.inst_addr", 32'(bus1.inst_addr), m_reg[1][0] & 255);
      chk("u1.read",      32'(bus1.read),      32'(m_rd[1]));
      chk("u1.write",     32'(bus1.write),     32'(m_wr[1]));
      chk("u1.address",   32'(bus1.address),   m_addr[1]);
      chk("u1.dout",      32'(bus1.dout),      m_dout[1]);
      chk("u1.halted",    32'(halted1),        32'(m_hlt[1]));
      for (int i = 0; i < 16; i++) chk($sformatf("u0.r%0d", i), 32'(dut0.regs[i]), m_reg[0][i]);
      for (int i = 0; i < 8; i++)  chk($sformatf("u1.r%0d", i), 32'(dut1.regs[i]), m_reg[1][i]);
   endtask

   // One clock: apply inputs, advance model, observe on the falling edge
   task automatic cycle(input bit r_rst, input bit r_run, input bit r_rdy);
      rst       = r_rst;
      run       = r_run;
      mem_ready = r_rdy;
      model_step(0);
      model_step(1);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) begin
         imem0[i] = 16'h0000;
         imem1[i] = 16'h0000;
      end
   endtask

   task automatic put(input int a, input logic [15:0] ins);
      imem0[a] = ins;
      imem1[a] = ins;
   endtask

   function automatic logic [15:0] rnd_inst();
      logic [15:0] ins;
      ins = 16'($urandom);
      if (ins[15:12] == 4'h0 && $urandom_range(0, 7) != 0) ins[11:8] = 4'h0;
      if ((ins[15:12] == 4'h3 || ins[15:12] == 4'h6 || ins[15:12] == 4'h7)
          && $urandom_range(0, 1) == 0) ins[7:0] = 8'($urandom_range(0, 17));
      return ins;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 256; i++) begin
         imem0[i] = rnd_inst();
         imem1[i] = rnd_inst();
      end
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b0;
      mem_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin
         dmem0[i] = 8'($urandom);
         dmem1[i] = 16'($urandom);
      end
      clear_imem();
      #1;

      // Reset state
      cycle(1'b1, 1'b0, 1'b0);
      chk("rst.inst_addr", 32'(bus0.inst_addr), 32'h0);
      chk("rst.halted",    32'(halted0),        32'h0);
      chk("rst.read",      32'(bus0.read),      32'h0);
      chk("rst.write",     32'(bus0.write),     32'h0);

      // SET R1,0xFF; SET R2,1; ADD R3,R1,R2 -> wraps to 0
      clear_imem();
      put(0, 16'h31FF);
      put(1, 16'h3201);
      put(2, 16'h8312);
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
      chk("add.r1",   32'(dut0.regs[1]),   32'hFF);
      chk("add.r3",   32'(dut0.regs[3]),   32'h00);
      chk("add.pc",   32'(bus0.inst_addr), 32'h3);
      chk("add16.r3", 32'(dut1.regs[3]),   32'h100);

      // LOAD R4,[R1+2] with a slow memory
      clear_imem();
      put(0, 16'h3110);
      put(1, 16'h1412);
      dmem0[8'h12] = 8'h5A;
      dmem1[8'h12] = 16'h005A;
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      chk("ld.read",    32'(bus0.read),    32'h1);
      chk("ld.address", 32'(bus0.address), 32'h12);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, i[0], 1'b0);
         chk("ld.read_hold", 32'(bus0.read),    32'h1);
         chk("ld.addr_hold", 32'(bus0.address), 32'h12);
      end
      cycle(1'b0, 1'b0, 1'b1);
      chk("ld.read_done", 32'(bus0.read),      32'h0);
      chk("ld.r4",        32'(dut0.regs[4]),   32'h5A);
      chk("ld.pc",        32'(bus0.inst_addr), 32'h2);

      // Branches and register jump
      clear_imem();
      put(0, 16'h3107);
      put(1, 16'h6107);
      put(3, 16'h7107);
      put(4, 16'h3020);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      chk("beq.pc",  32'(bus0.inst_addr), 32'h3);
      cycle(1'b0, 1'b1, 1'b0);
      chk("bneq.pc", 32'(bus0.inst_addr), 32'h4);
      cycle(1'b0, 1'b1, 1'b0);
      chk("jmp.pc",  32'(bus0.inst_addr), 32'h20);

      // Wide shifts on the 16-bit unit
      clear_imem();
      put(0, 16'h3101);
      put(1, 16'h3210);
      put(2, 16'hA312);
      put(3, 16'h320F);
      put(4, 16'hA312);
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
      chk("shl16.over", 32'(dut1.regs[3]), 32'h0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      chk("shl16.msb",  32'(dut1.regs[3]), 32'h8000);
      chk("shl8.over",  32'(dut0.regs[3]), 32'h0);

      // HALT freezes until reset
      clear_imem();
      put(3, 16'h0100);
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
      chk("halt.flag", 32'(halted0),        32'h1);
      chk("halt.pc",   32'(bus0.inst_addr), 32'h3);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'($urandom), 1'($urandom));
         chk("halt.hold", 32'(halted0),        32'h1);
         chk("halt.pcf",  32'(bus0.inst_addr), 32'h3);
      end
      cycle(1'b1, 1'b0, 1'b0);
      chk("halt.rst_flag", 32'(halted0),        32'h0);
      chk("halt.rst_pc",   32'(bus0.inst_addr), 32'h0);

      // Reset abandons a STORE in flight
      clear_imem();
      put(0, 16'h3133);
      put(1, 16'h3544);
      put(2, 16'h2511);
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
      chk("st.write",   32'(bus0.write),   32'h1);
      chk("st.dout",    32'(bus0.dout),    32'h44);
      chk("st.address", 32'(bus0.address), 32'h34);
      cycle(1'b0, 1'b0, 1'b0);
      chk("st.hold",    32'(bus0.write),   32'h1);
      cycle(1'b1, 1'b0, 1'b1);
      chk("st.rst_write", 32'(bus0.write),   32'h0);
      chk("st.rst_r1",    32'(dut0.regs[1]), 32'h0);
      chk("st.rst_r5",    32'(dut0.regs[5]), 32'h0);

      // Random programs under random run / mem_ready / reset
      fill_random();
      cycle(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < int'(NCYC); n++) begin
         if ($urandom_range(0, 199) == 0) begin
            fill_random();
            cycle(1'b1, 1'($urandom), 1'($urandom));
         end else begin
            cycle(1'b0, $urandom_range(0, 9) != 0, 1'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
